// File: rtl/decode_stage_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// decode_stage_pipelined_pkg : RV32 instruction/control types and decode helpers
// Rev 1.0
// ============================================================================
package decode_stage_pipelined_pkg;

  localparam int               REG_IDX_W = 5;
  localparam logic [4:0]       REG_ZERO  = 5'd0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_type;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } control_type;

  function automatic control_type decode_control(input instruction_type ins);
    control_type c;
    c = '0;
    case (ins.opcode)
      OP_R:      begin c.reg_write = 1'b1; c.alu_op = 2'b10; end
      OP_I:      begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 2'b11; end
      OP_LOAD:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; end
      OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_BRANCH: begin c.branch = 1'b1; c.alu_op = 2'b01; end
      OP_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Branch immediate is kept in halfword units; the target adder shifts it.
  function automatic logic [31:0] gen_imm(input instruction_type ins);
    logic [31:0] b;
    logic [31:0] r;
    b = ins;
    case (ins.opcode)
      OP_I, OP_LOAD: r = {{20{b[31]}}, b[31:20]};
      OP_STORE:      r = {{20{b[31]}}, b[31:25], b[11:7]};
      OP_BRANCH:     r = {{20{b[31]}}, b[31], b[7], b[30:25], b[11:8]};
      OP_LUI:        r = {b[31:12], 12'b0};
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_pipelined_if.sv
`default_nettype none
// ============================================================================
// decode_stage_pipelined_if : ID/EX pipeline register bundle (decode -> execute)
// Rev 1.0
// ============================================================================
interface decode_stage_pipelined_if #(
  parameter int XLEN = 32
);
  import decode_stage_pipelined_pkg::*;

  logic                 id_ex_valid;
  logic [XLEN-1:0]      data1;
  logic [XLEN-1:0]      data2;
  logic [XLEN-1:0]      imm;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  control_type          control;
  logic [XLEN-1:0]      pc_branch;
  logic [XLEN-1:0]      pc_out;

  modport master (output id_ex_valid, data1, data2, imm, rd, rs1, rs2, control, pc_branch, pc_out);
  modport slave  (input  id_ex_valid, data1, data2, imm, rd, rs1, rs2, control, pc_branch, pc_out);
endinterface
`default_nettype wire

// File: rtl/decode_stage_pipelined_hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit : load-use / write-back stall detection and bubble request
// Rev 1.0   (macro: DECODE_WB_BYPASS_EN removes the write-back stall)
// ============================================================================
module hazard_unit
  import decode_stage_pipelined_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_id,
  input  logic                 flush,
  output logic                 stall,
  output logic                 insert_bubble
);

  logic w_load_use;
  logic w_wb_stall;

  // rs2 is compared even for formats without rs2; the occasional extra stall is harmless.
  assign w_load_use = ex_mem_read && (ex_rd != REG_ZERO) && ((ex_rd == rs1) || (ex_rd == rs2));

`ifdef DECODE_WB_BYPASS_EN
  logic w_unused_wb;
  assign w_unused_wb = &{1'b0, wb_reg_write, wb_id};
  assign w_wb_stall  = 1'b0;
`else
  assign w_wb_stall = wb_reg_write && (wb_id != REG_ZERO) && ((wb_id == rs1) || (wb_id == rs2));
`endif

  assign stall         = !flush && (w_load_use || w_wb_stall);
  assign insert_bubble = flush || w_load_use || w_wb_stall;

endmodule
`default_nettype wire

// File: rtl/decode_stage_pipelined.sv
`default_nettype none
// ============================================================================
// decode_stage_pipelined : RV32 decode, register file and ID/EX register
// Rev 1.0   (macro: DECODE_WB_BYPASS_EN enables same-cycle WB forwarding)
// ============================================================================
module decode_stage_pipelined
  import decode_stage_pipelined_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  instruction_type      instruction,
  input  logic [XLEN-1:0]      pc,
  input  logic                 if_valid,
  input  logic                 flush,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_id,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 stall,
  decode_stage_pipelined_if.master id_ex
);

  control_type     w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_pc_branch;
  logic [XLEN-1:0] w_rf1, w_rf2;
  logic [XLEN-1:0] w_op1, w_op2;
  logic            w_bubble;

  logic [XLEN-1:0] r_regs [1:REG_COUNT-1];

  logic                 r_valid;
  logic [XLEN-1:0]      r_data1, r_data2, r_imm, r_pc_branch, r_pc_out;
  logic [REG_IDX_W-1:0] r_rd, r_rs1, r_rs2;
  control_type          r_control;

  assign w_ctrl      = decode_control(instruction);
  assign w_imm       = XLEN'($signed(gen_imm(instruction)));
  assign w_pc_branch = pc + (w_imm << 1);

  hazard_unit u_hazard (
    .rs1           (instruction.rs1),
    .rs2           (instruction.rs2),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_id         (wb_id),
    .flush         (flush),
    .stall         (stall),
    .insert_bubble (w_bubble)
  );

  // x0 and indices beyond REG_COUNT have no storage, so they read 0 and drop writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (wb_reg_write) begin
      for (int i = 1; i < REG_COUNT; i++)
        if (wb_id == REG_IDX_W'(i)) r_regs[i] <= wb_data;
    end
  end

  always_comb begin
    w_rf1 = '0;
    w_rf2 = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (instruction.rs1 == REG_IDX_W'(i)) w_rf1 = r_regs[i];
      if (instruction.rs2 == REG_IDX_W'(i)) w_rf2 = r_regs[i];
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  logic w_fwd1, w_fwd2;
  assign w_fwd1 = wb_reg_write && (wb_id != REG_ZERO) && (wb_id == instruction.rs1);
  assign w_fwd2 = wb_reg_write && (wb_id != REG_ZERO) && (wb_id == instruction.rs2);
  assign w_op1  = w_fwd1 ? wb_data : w_rf1;
  assign w_op2  = w_fwd2 ? wb_data : w_rf2;
`else
  assign w_op1 = w_rf1;
  assign w_op2 = w_rf2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || w_bubble) begin
      r_valid     <= 1'b0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_control   <= '0;
      r_pc_branch <= '0;
      r_pc_out    <= '0;
    end else begin
      r_valid     <= if_valid;
      r_data1     <= w_op1;
      r_data2     <= w_op2;
      r_imm       <= w_imm;
      r_rd        <= instruction.rd;
      r_rs1       <= instruction.rs1;
      r_rs2       <= instruction.rs2;
      r_control   <= w_ctrl;
      r_pc_branch <= w_pc_branch;
      r_pc_out    <= pc;
    end
  end

  assign id_ex.id_ex_valid = r_valid;
  assign id_ex.data1       = r_data1;
  assign id_ex.data2       = r_data2;
  assign id_ex.imm         = r_imm;
  assign id_ex.rd          = r_rd;
  assign id_ex.rs1         = r_rs1;
  assign id_ex.rs2         = r_rs2;
  assign id_ex.control     = r_control;
  assign id_ex.pc_branch   = r_pc_branch;
  assign id_ex.pc_out      = r_pc_out;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_pipelined : scoreboard bench driving RV32I and RV32E instances
// Rev 1.0
// ============================================================================
module tb_decode_stage_pipelined;
  import decode_stage_pipelined_pkg::*;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        if_valid;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_reg_write;
    logic [4:0]  wb_id;
    logic [31:0] wb_data;
    logic [31:0] eimm;
    control_type ectl;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    control_type ctrl;
    logic [31:0] pcb;
    logic [31:0] pco;
  } exp_t;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_LUI = 5, K_SYS = 6;

  logic            clk = 1'b0;
  logic            rst;
  instruction_type instruction;
  logic [31:0]     pc, wb_data;
  logic            if_valid, flush, ex_mem_read, wb_reg_write;
  logic [4:0]      ex_rd, wb_id;
  logic            stall_a, stall_b;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic [31:0] mreg [2][32];
  logic last_stall = 1'b0;

  always #5 clk = ~clk;

  decode_stage_pipelined_if #(.XLEN(32)) ifa ();
  decode_stage_pipelined_if #(.XLEN(32)) ifb ();

  decode_stage_pipelined #(.XLEN(32), .REG_COUNT(32)) dut32 (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .if_valid(if_valid),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_reg_write(wb_reg_write),
    .wb_id(wb_id), .wb_data(wb_data), .stall(stall_a), .id_ex(ifa)
  );

  decode_stage_pipelined #(.XLEN(32), .REG_COUNT(16)) dut16 (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .if_valid(if_valid),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_reg_write(wb_reg_write),
    .wb_id(wb_id), .wb_data(wb_data), .stall(stall_b), .id_ex(ifb)
  );

  // Build an instruction from its kind and chosen fields; the expected immediate
  // and control come straight from the chosen values, not from re-decoding bits.
  function automatic stim_t mk(int kind, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                               logic [19:0] rnd);
    stim_t s;
    logic [11:0] h;
    h = rnd[11:0];
    s = '{rst: 1'b1, ins: '0, pc: '0, if_valid: 1'b1, flush: 1'b0, ex_mem_read: 1'b0,
          ex_rd: '0, wb_reg_write: 1'b0, wb_id: '0, wb_data: '0, eimm: '0, ectl: '0};
    case (kind)
      K_R: begin
        s.ins = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
        s.ectl.reg_write = 1'b1; s.ectl.alu_op = 2'b10;
      end
      K_I: begin
        s.ins = {h, rs1, 3'b000, rd, 7'b0010011};
        s.eimm = {{20{h[11]}}, h};
        s.ectl.reg_write = 1'b1; s.ectl.alu_src = 1'b1; s.ectl.alu_op = 2'b11;
      end
      K_LOAD: begin
        s.ins = {h, rs1, 3'b010, rd, 7'b0000011};
        s.eimm = {{20{h[11]}}, h};
        s.ectl.reg_write = 1'b1; s.ectl.mem_read = 1'b1; s.ectl.mem_to_reg = 1'b1;
        s.ectl.alu_src = 1'b1;
      end
      K_STORE: begin
        s.ins = {h[11:5], rs2, rs1, 3'b010, h[4:0], 7'b0100011};
        s.eimm = {{20{h[11]}}, h};
        s.ectl.mem_write = 1'b1; s.ectl.alu_src = 1'b1;
      end
      K_BR: begin
        s.ins = {h[11], h[9:4], rs2, rs1, 3'b000, h[3:0], h[10], 7'b1100011};
        s.eimm = {{20{h[11]}}, h};
        s.ectl.branch = 1'b1; s.ectl.alu_op = 2'b01;
      end
      K_LUI: begin
        s.ins = {rnd, rd, 7'b0110111};
        s.eimm = {rnd, 12'b0};
        s.ectl.reg_write = 1'b1; s.ectl.alu_src = 1'b1;
      end
      default: s.ins = {h, rs1, 3'b000, rd, 7'b1110011};
    endcase
    return s;
  endfunction

  function automatic logic [4:0] rand_idx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = mk($urandom_range(0, 6), rand_idx(), rand_idx(), rand_idx(), 20'($urandom));
    s.pc           = $urandom;
    s.if_valid     = ($urandom_range(0, 4) != 0);
    s.flush        = ($urandom_range(0, 9) == 0);
    s.ex_mem_read  = ($urandom_range(0, 2) == 0);
    s.ex_rd        = rand_idx();
    s.wb_reg_write = ($urandom_range(0, 1) == 0);
    s.wb_id        = rand_idx();
    s.wb_data      = $urandom;
    return s;
  endfunction

  function automatic logic [31:0] model_read(int k, logic [4:0] idx);
    int cnt;
    cnt = (k == 0) ? 32 : 16;
    if (idx == 5'd0 || int'(idx) >= cnt) return 32'd0;
    return mreg[k][idx];
  endfunction

  task automatic step(input stim_t s);
    logic [4:0] a, b;
    logic       lu, wbhit, bs, bubble;
    exp_t       e;
    @(negedge clk);
    rst = s.rst; instruction = s.ins; pc = s.pc; if_valid = s.if_valid; flush = s.flush;
    ex_mem_read = s.ex_mem_read; ex_rd = s.ex_rd; wb_reg_write = s.wb_reg_write;
    wb_id = s.wb_id; wb_data = s.wb_data;

    a     = s.ins[19:15];
    b     = s.ins[24:20];
    lu    = s.ex_mem_read && s.ex_rd != 0 && (s.ex_rd == a || s.ex_rd == b);
    wbhit = s.wb_reg_write && s.wb_id != 0 && (s.wb_id == a || s.wb_id == b);
`ifdef DECODE_WB_BYPASS_EN
    bs = 1'b0;
`else
    bs = wbhit;
`endif
    bubble = s.flush || lu || bs;

    for (int k = 0; k < 2; k++) begin
      e = '0;
      e.stall = !s.flush && (lu || bs);
      if (s.rst && !bubble) begin
        e.valid = s.if_valid;
        e.d1    = (s.wb_reg_write && s.wb_id != 0 && s.wb_id == a) ? s.wb_data : model_read(k, a);
        e.d2    = (s.wb_reg_write && s.wb_id != 0 && s.wb_id == b) ? s.wb_data : model_read(k, b);
        e.imm   = s.eimm;
        e.rd    = s.ins[11:7];
        e.rs1   = a;
        e.rs2   = b;
        e.ctrl  = s.ectl;
        e.pcb   = s.pc + (s.eimm << 1);
        e.pco   = s.pc;
      end
      q.push_back(e);
    end

    for (int k = 0; k < 2; k++) begin
      if (!s.rst) begin
        for (int r = 0; r < 32; r++) mreg[k][r] = '0;
      end else if (s.wb_reg_write && s.wb_id != 0 && int'(s.wb_id) < ((k == 0) ? 32 : 16)) begin
        mreg[k][s.wb_id] = s.wb_data;
      end
    end
    last_stall = !s.flush && (lu || bs);
  endtask

  task automatic compare(input exp_t act, input exp_t exp, input string tag);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h required %h", tag, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per instance per clock edge.
  initial begin
    exp_t ea, eb, aa, ab;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() >= 2) begin
        ea = q.pop_front();
        eb = q.pop_front();
        aa = {stall_a, ifa.id_ex_valid, ifa.data1, ifa.data2, ifa.imm, ifa.rd, ifa.rs1,
              ifa.rs2, ifa.control, ifa.pc_branch, ifa.pc_out};
        ab = {stall_b, ifb.id_ex_valid, ifb.data1, ifb.data2, ifb.imm, ifb.rd, ifb.rs1,
              ifb.rs2, ifb.control, ifb.pc_branch, ifb.pc_out};
        compare(aa, ea, "rv32i_bundle");
        compare(ab, eb, "rv32e_bundle");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t s, prev;
    rst = 1'b0; instruction = '0; pc = '0; if_valid = 1'b0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; wb_reg_write = 1'b0; wb_id = '0; wb_data = '0;
    for (int k = 0; k < 2; k++) for (int r = 0; r < 32; r++) mreg[k][r] = '0;

    for (int n = 0; n < 3; n++) begin
      s = rand_stim(); s.rst = 1'b0; step(s);
    end
    s = mk(K_I, 5'd1, 5'd0, 5'd0, 20'd5); s.pc = 32'h100; step(s);

    // load-use on x3, then the held ADD is accepted once the load leaves EX
    s = mk(K_R, 5'd4, 5'd3, 5'd2, 20'd0); s.ex_mem_read = 1'b1; s.ex_rd = 5'd3; step(s);
    s.ex_mem_read = 1'b0; step(s);
    s.ex_mem_read = 1'b1; s.flush = 1'b1; step(s);

    s = mk(K_R, 5'd6, 5'd5, 5'd0, 20'd0);
    s.wb_reg_write = 1'b1; s.wb_id = 5'd5; s.wb_data = 32'hDEADBEEF; step(s);
    s.wb_reg_write = 1'b0; step(s);

    s = mk(K_I, 5'd0, 5'd0, 5'd0, 20'd0);
    s.wb_reg_write = 1'b1; s.wb_id = 5'd0; s.wb_data = 32'h1234; step(s);
    s = mk(K_R, 5'd1, 5'd0, 5'd0, 20'd0); step(s);

    s = mk(K_I, 5'd2, 5'd1, 5'd0, 20'd7);
    s.wb_reg_write = 1'b1; s.wb_id = 5'd20; s.wb_data = 32'h0000ABCD; step(s);
    s = mk(K_R, 5'd1, 5'd20, 5'd20, 20'd0); step(s);

    s = mk(K_I, 5'd1, 5'd0, 5'd0, 20'h10); s.pc = 32'hFFFFFFF0; step(s);
    s = mk(K_BR, 5'd0, 5'd0, 5'd0, 20'hFFF); s.pc = 32'h0; step(s);

    prev = s;
    for (int n = 0; n < 400; n++) begin
      s = rand_stim();
      if (last_stall) begin
        s.ins = prev.ins; s.pc = prev.pc; s.eimm = prev.eimm; s.ectl = prev.ectl;
        s.if_valid = prev.if_valid;
      end
      s.rst = !(n >= 150 && n < 153);
      step(s);
      prev = s;
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
